// File: rtl/jk_ff_bank.sv
// rtl/jk_ff_bank.sv - multi-mode (JK/D/T/SR) flip-flop bank with change tracking
//
// Purpose:
//   WIDTH independent flops sharing one clock and one run-time mode.
//   Adds a clock enable, a synchronous set-all, a per-bit change pulse,
//   a saturating count of edges with any change, and a sticky flag for
//   illegal SR pairs.
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset_n  in   1      synchronous active-low reset
//   en       in   1      update enable (0 = hold all channels)
//   set      in   1      force all q bits to 1 (overrides en and mode)
//   mode     in   2      00 JK, 01 D, 10 T, 11 SR
//   j        in   WIDTH  J / D / T / S per channel
//   k        in   WIDTH  K / R per channel (unused in D and T)
//   clr_err  in   1      clears sr_err
//   q        out  WIDTH  registered state
//   qb       out  WIDTH  registered complement of q
//   changed  out  WIDTH  one-cycle pulse per bit that changed on last edge
//   chg_cnt  out  CNT_W  saturating count of edges where q changed
//   sr_err   out  1      sticky illegal-SR flag

module jk_ff_bank #(
    parameter int                 WIDTH = 8,
    parameter int                 CNT_W = 16,
    parameter logic [WIDTH-1:0]   RST_Q = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             set,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] changed,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             sr_err
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    mode_e            mode_sel;
    logic [WIDTH-1:0] mode_q;
    logic [WIDTH-1:0] next_q;
    logic             any_change;
    logic             sr_illegal;
    logic             next_err;

    assign mode_sel = mode_e'(mode);

    // Per-channel next state for the selected mode, evaluated as if en=1.
    always_comb begin
        mode_q = q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (mode_sel)
                MODE_JK: begin
                    unique case ({j[i], k[i]})
                        2'b00:   mode_q[i] = q[i];
                        2'b01:   mode_q[i] = 1'b0;
                        2'b10:   mode_q[i] = 1'b1;
                        default: mode_q[i] = ~q[i];
                    endcase
                end
                MODE_D: mode_q[i] = j[i];
                MODE_T: mode_q[i] = q[i] ^ j[i];
                default: begin
                    // S=R=1 holds the bit; the error is reported separately.
                    unique case ({j[i], k[i]})
                        2'b10:   mode_q[i] = 1'b1;
                        2'b01:   mode_q[i] = 1'b0;
                        default: mode_q[i] = q[i];
                    endcase
                end
            endcase
        end
    end

    // Priority below reset: set > hold (en=0) > mode logic.
    always_comb begin
        next_q = q;
        if (set) begin
            next_q = {WIDTH{1'b1}};
        end else if (en) begin
            next_q = mode_q;
        end
    end

    assign any_change = (next_q != q);

    // A fresh illegal pair beats a coincident clear so it is never lost.
    assign sr_illegal = en && !set && (mode_sel == MODE_SR) && (|(j & k));

    always_comb begin
        next_err = sr_err;
        if (sr_illegal) begin
            next_err = 1'b1;
        end else if (clr_err) begin
            next_err = 1'b0;
        end
    end

    // qb is its own register so it carries no inverter delay after q.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q       <= RST_Q;
            qb      <= ~RST_Q;
            changed <= '0;
            chg_cnt <= '0;
            sr_err  <= 1'b0;
        end else begin
            q       <= next_q;
            qb      <= ~next_q;
            changed <= next_q ^ q;
            if (any_change && (chg_cnt != CNT_MAX)) begin
                chg_cnt <= chg_cnt + CNT_W'(1);
            end
            sr_err  <= next_err;
        end
    end

endmodule

// File: tb/tb_jk_ff_bank.sv
// tb/tb_jk_ff_bank.sv - scoreboard testbench for jk_ff_bank

module tb_jk_ff_bank;

    localparam logic [7:0] RST_VAL = 8'hA5;

    logic       clk = 1'b0;
    logic       reset_n, en, set, clr_err;
    logic [1:0] mode;
    logic [7:0] j, k;

    logic [7:0]  q, qb, changed;
    logic [15:0] chg_cnt;
    logic        sr_err;

    logic [7:0]  q2, qb2, changed2;
    logic [1:0]  chg_cnt2;
    logic        sr_err2;

    always #5 clk = ~clk;

    jk_ff_bank #(.WIDTH(8), .CNT_W(16), .RST_Q(RST_VAL)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .set(set), .mode(mode),
        .j(j), .k(k), .clr_err(clr_err),
        .q(q), .qb(qb), .changed(changed), .chg_cnt(chg_cnt), .sr_err(sr_err)
    );

    jk_ff_bank #(.WIDTH(8), .CNT_W(2), .RST_Q(RST_VAL)) dut_sat (
        .clk(clk), .reset_n(reset_n), .en(en), .set(set), .mode(mode),
        .j(j), .k(k), .clr_err(clr_err),
        .q(q2), .qb(qb2), .changed(changed2), .chg_cnt(chg_cnt2), .sr_err(sr_err2)
    );

    typedef struct packed {
        logic [7:0]  q;
        logic [7:0]  qb;
        logic [7:0]  ch;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic        err;
    } exp_t;

    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  mq;
    logic [15:0] mcnt;
    logic [1:0]  mcnt2;
    logic        merr;

    // Drive one edge of stimulus, push the reference result, then compare
    // once the DUT has registered it.
    task automatic apply(input string name, input logic rn, input logic st,
                         input logic e, input logic [1:0] md,
                         input logic [7:0] jj, input logic [7:0] kk,
                         input logic ce);
        logic [7:0] nq;
        exp_t x;
        exp_t got;
        reset_n = rn; set = st; en = e; mode = md; j = jj; k = kk; clr_err = ce;
        if (!rn) begin
            nq = RST_VAL; x.ch = 8'h00; mcnt = 16'd0; mcnt2 = 2'd0; merr = 1'b0;
        end else begin
            if (st) nq = 8'hFF;
            else if (!e) nq = mq;
            else begin
                for (int i = 0; i < 8; i++) begin
                    case (md)
                        2'b00: nq[i] = (jj[i] & ~mq[i]) | (~kk[i] & mq[i]);
                        2'b01: nq[i] = jj[i];
                        2'b10: nq[i] = jj[i] ? ~mq[i] : mq[i];
                        default: nq[i] = (jj[i] & ~kk[i]) ? 1'b1 :
                                         (~jj[i] & kk[i]) ? 1'b0 : mq[i];
                    endcase
                end
            end
            x.ch = nq ^ mq;
            if (nq != mq) begin
                if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
                if (mcnt2 != 2'd3) mcnt2 = mcnt2 + 2'd1;
            end
            if (e && !st && md == 2'b11 && (jj & kk) != 8'h00) merr = 1'b1;
            else if (ce) merr = 1'b0;
        end
        mq = nq;
        x.q = nq; x.qb = ~nq; x.cnt = mcnt; x.cnt2 = mcnt2; x.err = merr;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        vectors++;
        if (q !== got.q) begin
            miscompares++; $display("FAIL %s q: got %h expected %h", name, q, got.q);
        end
        vectors++;
        if (qb !== got.qb) begin
            miscompares++; $display("FAIL %s qb: got %h expected %h", name, qb, got.qb);
        end
        vectors++;
        if (changed !== got.ch) begin
            miscompares++; $display("FAIL %s changed: got %h expected %h", name, changed, got.ch);
        end
        vectors++;
        if (chg_cnt !== got.cnt) begin
            miscompares++; $display("FAIL %s chg_cnt: got %0d expected %0d", name, chg_cnt, got.cnt);
        end
        vectors++;
        if (chg_cnt2 !== got.cnt2) begin
            miscompares++; $display("FAIL %s chg_cnt_sat: got %0d expected %0d", name, chg_cnt2, got.cnt2);
        end
        vectors++;
        if (sr_err !== got.err) begin
            miscompares++; $display("FAIL %s sr_err: got %b expected %b", name, sr_err, got.err);
        end
    endtask

    task automatic test_reset();
        apply("reset0", 1'b0, 1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b1);
        apply("reset1", 1'b0, 1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b1);
        vectors++;
        if (q !== 8'hA5 || qb !== 8'h5A || changed !== 8'h00 || chg_cnt !== 16'd0 || sr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: got q=%h qb=%h ch=%h cnt=%0d err=%b expected q=a5 qb=5a ch=00 cnt=0 err=0",
                     q, qb, changed, chg_cnt, sr_err);
        end
        apply("to_zero", 1'b1, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 1'b0);
        // Reset dropped between edges must not disturb q before the next edge.
        reset_n = 1'b0;
        #3;
        vectors++;
        if (q !== 8'h00) begin
            miscompares++; $display("FAIL reset_async: got q=%h expected 00", q);
        end
        apply("reset_edge", 1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_jk();
        apply("jk_clear", 1'b1, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 1'b0);
        apply("jk_setrst", 1'b1, 1'b0, 1'b1, 2'b00, 8'hF0, 8'h0F, 1'b0);
        apply("jk_toggle", 1'b1, 1'b0, 1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);
        apply("jk_hold", 1'b1, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
        vectors++;
        if (q !== 8'h0F) begin
            miscompares++; $display("FAIL jk_final: got q=%h expected 0f", q);
        end
    endtask

    task automatic test_d_t_en();
        apply("d_load", 1'b1, 1'b0, 1'b1, 2'b01, 8'h3C, 8'hA5, 1'b0);
        apply("t_toggle", 1'b1, 1'b0, 1'b1, 2'b10, 8'h0F, 8'hFF, 1'b0);
        vectors++;
        if (q !== 8'h33 || changed !== 8'h0F) begin
            miscompares++; $display("FAIL t_result: got q=%h ch=%h expected q=33 ch=0f", q, changed);
        end
        apply("en_hold", 1'b1, 1'b0, 1'b0, 2'b10, 8'hFF, 8'hFF, 1'b0);
    endtask

    task automatic test_sr();
        apply("sr_clear", 1'b1, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 1'b0);
        apply("sr_illegal", 1'b1, 1'b0, 1'b1, 2'b11, 8'h81, 8'h01, 1'b0);
        vectors++;
        if (q !== 8'h80 || sr_err !== 1'b1) begin
            miscompares++; $display("FAIL sr_first: got q=%h err=%b expected q=80 err=1", q, sr_err);
        end
        apply("sr_set_wins", 1'b1, 1'b0, 1'b1, 2'b11, 8'h02, 8'h02, 1'b1);
        apply("sr_clr", 1'b1, 1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 1'b1);
        apply("sr_en0", 1'b1, 1'b0, 1'b0, 2'b11, 8'hFF, 8'hFF, 1'b0);
        apply("sr_set_low", 1'b1, 1'b0, 1'b1, 2'b11, 8'h01, 8'h00, 1'b0);
        apply("sr_rst", 1'b1, 1'b0, 1'b1, 2'b11, 8'h00, 8'h81, 1'b0);
    endtask

    task automatic test_set_priority();
        apply("set_load12", 1'b1, 1'b0, 1'b1, 2'b01, 8'h12, 8'h00, 1'b0);
        apply("set_en0", 1'b1, 1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 1'b0);
        vectors++;
        if (changed !== 8'hED || q !== 8'hFF || qb !== 8'h00) begin
            miscompares++; $display("FAIL set_result: got q=%h qb=%h ch=%h expected q=ff qb=00 ch=ed", q, qb, changed);
        end
        apply("set_again", 1'b1, 1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0);
        apply("set_vs_rst", 1'b0, 1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_saturation();
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic prev;
        apply("sat_rst", 1'b0, 1'b0, 1'b0, 2'b10, 8'h00, 8'h00, 1'b0);
        for (int n = 0; n < 5; n++) begin
            prev = q2[0];
            apply("sat_toggle", 1'b1, 1'b0, 1'b1, 2'b10, 8'h01, 8'h00, 1'b0);
            vectors++;
            if (chg_cnt2 !== want[n] || q2[0] === prev) begin
                miscompares++;
                $display("FAIL sat_step%0d: got cnt=%0d q0=%b expected cnt=%0d q0=%b", n, chg_cnt2, q2[0], want[n], ~prev);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic rn;
        for (int n = 0; n < 40; n++) begin
            rn = ($urandom_range(0, 15) != 0);
            apply("random", rn, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        reset_n = 1'b0; set = 1'b0; en = 1'b0; mode = 2'b00;
        j = 8'h00; k = 8'h00; clr_err = 1'b0;
        mq = RST_VAL; mcnt = 16'd0; mcnt2 = 2'd0; merr = 1'b0;
        test_reset();
        test_jk();
        test_d_t_en();
        test_sr();
        test_set_priority();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
